// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencer.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_PC     = 2'b10;
  localparam logic [1:0] WHO_NONE    = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PLAYER,
    ST_COMPUTER,
    ST_RELEASE,
    ST_OVER
  } state_t;

  // Index of the lowest set bit; meaningful only for a one-hot vector.
  function automatic logic [3:0] cell_index(input logic [NUM_CELLS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ttt_btn_debounce.sv
// Button debouncer: two-flop synchroniser, stability counter and the
// accepted (stable) button vector, plus a pulse when a press begins.
module ttt_btn_debounce
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CELLS-1:0] btn,
  output logic [NUM_CELLS-1:0] stable_btn,
  output logic                 press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_CELLS-1:0] sync_p0;
  logic [NUM_CELLS-1:0] sync_p1;
  logic [CNT_W-1:0]     cnt;

  // Synchronise, count unchanged samples, and accept the vector once it has
  // been steady long enough; press_evt fires on the all-zero to non-zero step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      cnt        <= '0;
      stable_btn <= '0;
      press_evt  <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0   <= btn;
      sync_p1   <= sync_p0;
      press_evt <= 1'b0;
      if (sync_p0 != sync_p1) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end else if (stable_btn != sync_p1) begin
        stable_btn <= sync_p1;
        press_evt  <= (stable_btn == '0);
      end
    end
  end

endmodule

// File: rtl/ttt_move_sequencer.sv
// Turns debounced player buttons into the game's play/pc move handshake.
// Build option: define TTT_CENTRE_FIRST_EN to make the computer prefer the
// centre, then corners, then edges; otherwise it takes the lowest empty cell.
module ttt_move_sequencer
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  btn,
  input  logic [17:0] board,
  input  logic [1:0]  who,
  output logic        play,
  output logic        pc,
  output logic [3:0]  player_position,
  output logic [3:0]  computer_position,
  output logic        busy,
  output logic        illegal
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

`ifdef TTT_CENTRE_FIRST_EN
  localparam logic [3:0] PICK_ORDER [NUM_CELLS] =
    '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
`else
  localparam logic [3:0] PICK_ORDER [NUM_CELLS] =
    '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
`endif

  // First free cell in preference order; returns {found, index}.
  function automatic logic [4:0] pick_cell(input logic [NUM_CELLS-1:0] taken);
    logic       found;
    logic [3:0] idx;
    found = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (!found && !taken[PICK_ORDER[k]]) begin
        found = 1'b1;
        idx   = PICK_ORDER[k];
      end
    end
    return {found, idx};
  endfunction

  state_t               state, state_d;
  logic [NUM_CELLS-1:0] lat_btn, lat_d;
  logic [HOLD_W-1:0]    hold_cnt, hold_d;
  logic [3:0]           ppos_d, cpos_d;
  logic [NUM_CELLS-1:0] stable_btn;
  logic                 press_evt;
  logic [NUM_CELLS-1:0] occ;
  logic [NUM_CELLS-1:0] masked;
  logic [4:0]           sel;
  logic                 hold_done;

  ttt_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .btn        (btn),
    .stable_btn (stable_btn),
    .press_evt  (press_evt)
  );

  // Occupancy map of the board; code 11 counts as occupied.
  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      occ[i] = (board[2*i +: 2] != CELL_EMPTY);
    end
  end

  assign masked    = occ | (9'd1 << player_position);
  assign sel       = pick_cell(masked);
  assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Latched press, hold counter and the move positions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_btn           <= '0;
      hold_cnt          <= '0;
      player_position   <= '0;
      computer_position <= '0;
    end else begin
      lat_btn           <= lat_d;
      hold_cnt          <= hold_d;
      player_position   <= ppos_d;
      computer_position <= cpos_d;
    end
  end

  // Next-state logic, move selection and the illegal-press pulse.
  always_comb begin
    state_d = state;
    lat_d   = lat_btn;
    hold_d  = hold_cnt;
    ppos_d  = player_position;
    cpos_d  = computer_position;
    illegal = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (who != WHO_NONE) begin
          state_d = ST_OVER;
        end else if (press_evt) begin
          lat_d   = stable_btn;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!$onehot(lat_btn) || ((lat_btn & occ) != '0)) begin
          illegal = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          ppos_d  = cell_index(lat_btn);
          hold_d  = '0;
          state_d = ST_PLAYER;
        end
      end
      ST_PLAYER: begin
        if (hold_done) begin
          hold_d = '0;
          if (sel[4]) begin
            cpos_d  = sel[3:0];
            state_d = ST_COMPUTER;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      ST_COMPUTER: begin
        if (hold_done) begin
          hold_d  = '0;
          state_d = ST_RELEASE;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stable_btn == '0) begin
          state_d = (who != WHO_NONE) ? ST_OVER : ST_IDLE;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so reset drops them immediately.
  assign play = (state == ST_PLAYER);
  assign pc   = (state == ST_COMPUTER);
  assign busy = (state != ST_IDLE) && (state != ST_OVER);

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Self-checking bench for ttt_move_sequencer: directed table, random moves
// against a transaction-level model, plus reset and game-over sequences.
module tb_ttt_move_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  btn;
  logic [17:0] board;
  logic [1:0]  who;
  logic        play, pc, busy, illegal;
  logic [3:0]  player_position, computer_position;

  int errors = 0;
  int checks = 0;

  // Monitor totals
  int tot_play_cyc = 0, tot_play_rise = 0, tot_pc_cyc = 0, tot_pc_rise = 0;
  int tot_ill = 0, overlap = 0, ppos_seen = 0, cpos_seen = 0;
  bit play_q = 0, pc_q = 0;

`ifdef TTT_CENTRE_FIRST_EN
  localparam int ORDER [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
`else
  localparam int ORDER [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
`endif

  typedef struct {
    logic [17:0] brd;
    logic [8:0]  b;
    bit          ill;
    bit          ply;
    int          ppos;
    bit          pcm;
    int          cpos;
  } vec_t;

  vec_t tbl[6];

  ttt_move_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .btn               (btn),
    .board             (board),
    .who               (who),
    .play              (play),
    .pc                (pc),
    .player_position   (player_position),
    .computer_position (computer_position),
    .busy              (busy),
    .illegal           (illegal)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (play) begin
      tot_play_cyc++;
      ppos_seen = int'(player_position);
      if (!play_q) tot_play_rise++;
    end
    if (pc) begin
      tot_pc_cyc++;
      cpos_seen = int'(computer_position);
      if (!pc_q) tot_pc_rise++;
    end
    if (illegal) tot_ill++;
    if (play && pc) overlap++;
    play_q = play;
    pc_q   = pc;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Game rules: a press is legal if exactly one button and that cell empty;
  // the computer then takes the first free cell in preference order.
  task automatic model(input logic [17:0] brd, input logic [8:0] b,
                       output bit ill, output bit ply, output int ppos,
                       output bit pcm, output int cpos);
    bit taken[9];
    int n;
    n = 0; ppos = 0; cpos = 0; ill = 0; ply = 0; pcm = 0;
    for (int i = 0; i < 9; i++) begin
      taken[i] = (brd[2*i +: 2] != 2'b00);
      if (b[i]) begin n++; ppos = i; end
    end
    if (n != 1 || taken[ppos]) begin
      ill = 1;
    end else begin
      ply = 1;
      taken[ppos] = 1;
      for (int k = 0; k < 9; k++) begin
        if (!pcm && !taken[ORDER[k]]) begin pcm = 1; cpos = ORDER[k]; end
      end
    end
  endtask

  task automatic bounce(input logic [8:0] v, input logic [8:0] final_v);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      btn = ($urandom % 2) ? v : 9'd0;
    end
    @(negedge clock);
    btn = final_v;
  endtask

  task automatic wait_busy(input bit lvl, input int budget, output bit ok);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (busy === lvl);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int s_pc, s_pr, s_cc, s_cr, s_il, s_ov;
    bit ok;
    @(negedge clock);
    board = v.brd;
    who   = 2'b00;
    s_pc = tot_play_cyc; s_pr = tot_play_rise; s_cc = tot_pc_cyc;
    s_cr = tot_pc_rise;  s_il = tot_ill;       s_ov = overlap;
    bounce(v.b, v.b);
    wait_busy(1'b1, 200, ok);
    chk({tag, " busy_rise"}, int'(ok), 1);
    repeat (5) @(negedge clock);
    bounce(v.b, 9'd0);
    wait_busy(1'b0, 200, ok);
    chk({tag, " busy_fall"}, int'(ok), 1);
    repeat (3) @(negedge clock);
    chk({tag, " illegal_pulses"}, tot_ill - s_il, v.ill ? 1 : 0);
    chk({tag, " play_cycles"}, tot_play_cyc - s_pc, v.ply ? 5 : 0);
    chk({tag, " play_strobes"}, tot_play_rise - s_pr, v.ply ? 1 : 0);
    chk({tag, " pc_cycles"}, tot_pc_cyc - s_cc, v.pcm ? 5 : 0);
    chk({tag, " pc_strobes"}, tot_pc_rise - s_cr, v.pcm ? 1 : 0);
    chk({tag, " play_pc_overlap"}, overlap - s_ov, 0);
    if (v.ply) chk({tag, " player_position"}, ppos_seen, v.ppos);
    if (v.pcm) chk({tag, " computer_position"}, cpos_seen, v.cpos);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bit   ok;
    int   s_pc, s_cc, s_il, busy_hi;

    // Directed table
    tbl[0] = '{18'h00000, 9'b000000001, 0, 1, 0, 1, 1};
`ifdef TTT_CENTRE_FIRST_EN
    tbl[0].cpos = 4;
`endif
    tbl[1] = '{18'h00010, 9'b000000100, 1, 0, 0, 0, 0};
    tbl[2] = '{18'h00000, 9'b000010001, 1, 0, 0, 0, 0};
    tbl[3] = '{18'h0AAAA, 9'b100000000, 0, 1, 8, 0, 0};
    tbl[4] = '{18'h00009, 9'b000010000, 0, 1, 4, 1, 2};
    tbl[5] = '{18'h000C0, 9'b000001000, 1, 0, 0, 0, 0};

    reset = 1'b1; btn = '0; board = '0; who = 2'b00;
    repeat (3) @(negedge clock);
    chk("reset play", int'(play), 0);
    chk("reset pc", int'(pc), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset illegal", int'(illegal), 0);
    chk("reset ppos", int'(player_position), 0);
    chk("reset cpos", int'(computer_position), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Random moves against the model
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 9; i++) begin
        int r;
        r = $urandom_range(0, 5);
        v.brd[2*i +: 2] = (r <= 2) ? 2'b00 : (r == 3) ? 2'b01 : (r == 4) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 9) < 7) v.b = 9'd1 << $urandom_range(0, 8);
      else v.b = 9'($urandom);
      if (v.b == 9'd0) v.b = 9'b000000011;
      model(v.brd, v.b, v.ill, v.ply, v.ppos, v.pcm, v.cpos);
      run_txn(v, $sformatf("rnd%0d", t));
    end

    // Reset in the middle of the player strobe
    @(negedge clock);
    board = '0;
    bounce(9'b000100000, 9'b000100000);
    begin
      int n;
      n = 0;
      while (!play && n < 200) begin @(negedge clock); n++; end
    end
    chk("midreset play_seen", int'(play), 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset play_async", int'(play), 0);
    chk("midreset pc_async", int'(pc), 0);
    chk("midreset busy_async", int'(busy), 0);
    btn = '0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset ppos", int'(player_position), 0);
    chk("midreset cpos", int'(computer_position), 0);
    chk("midreset illegal", int'(illegal), 0);
    s_pc = tot_play_cyc;
    repeat (30) @(negedge clock);
    chk("midreset no_replay", tot_play_cyc - s_pc, 0);

    // Game ends during a move: OVER after release, presses ignored
    board = '0;
    bounce(9'b000010000, 9'b000010000);
    wait_busy(1'b1, 200, ok);
    chk("over busy_rise", int'(ok), 1);
    who = 2'b01;
    repeat (3) @(negedge clock);
    bounce(9'b000010000, 9'd0);
    wait_busy(1'b0, 200, ok);
    chk("over busy_fall", int'(ok), 1);
    s_pc = tot_play_cyc; s_cc = tot_pc_cyc; s_il = tot_ill; busy_hi = 0;
    bounce(9'b000000001, 9'b000000001);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (busy) busy_hi++;
    end
    chk("over busy_cycles", busy_hi, 0);
    chk("over play_cycles", tot_play_cyc - s_pc, 0);
    chk("over pc_cycles", tot_pc_cyc - s_cc, 0);
    chk("over illegal", tot_ill - s_il, 0);
    btn = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    who = 2'b00;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    run_txn(tbl[4], "after_over");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttt_move_sequencer.md
Name: ttt_move_sequencer

Overview:
- Upstream input stage for tic_tac_toe_game.
- Turns nine raw player push-buttons into the game's move handshake: debounced player move first, then an automatically chosen computer move.
- Drives play, pc, player_position and computer_position into the game.
- Reads the game's board state (pos1..pos9) and who back, so it never issues a move onto an occupied cell or after the game has ended.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical samples required before a button vector is accepted as stable.
- HOLD_CYCLES, 5: number of clock cycles that play, and separately pc, are held high for each move.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn  input  9  raw, bouncy player buttons; bit i selects cell i (0..8, row-major).
- board  input  18  game cell states, bits [2i+1:2i] = pos(i+1); 00 empty, 01 player, 10 computer, 11 treated as occupied.
- who  input  2  game result; 00 in progress, any other value means the game is over.
- play  output  1  player-move strobe into the game.
- pc  output  1  computer-move strobe into the game.
- player_position  output  4  cell index of the player move, 0..8.
- computer_position  output  4  cell index of the computer move, 0..8.
- busy  output  1  high in any state other than IDLE or OVER.
- illegal  output  1  one-cycle pulse when a rejected press is detected.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; all outputs = 0.
  - Debounce counter and stable vector cleared.
  - Applies mid-move as well: play and pc drop in the same cycle reset asserts.
- Debounce:
  - btn is double-flop synchronised.
  - A counter restarts whenever the synchronised vector changes.
  - After DEBOUNCE_CYCLES unchanged samples, the value is copied into stable_btn.
  - A press event = stable_btn goes from all-zero to non-zero.
- FSM states: IDLE, CHECK, PLAYER, COMPUTER, RELEASE, OVER.
- IDLE:
  - If who != 00, go to OVER.
  - On a press event, latch stable_btn and go to CHECK.
- CHECK (1 cycle):
  - Reject the press if the latched vector is not one-hot, or if the selected cell's board field != 00.
  - On reject: illegal = 1 for this cycle, go to RELEASE.
  - Otherwise: player_position = encoded index, go to PLAYER.
- PLAYER:
  - play = 1, pc = 0 for exactly HOLD_CYCLES cycles.
  - Computer move selection happens in the last PLAYER cycle, from board with the player's cell masked as occupied.
  - Default selection = lowest-index empty cell.
  - If no empty cell remains, skip COMPUTER and go to RELEASE.
  - Otherwise computer_position = the selected cell, go to COMPUTER.
- COMPUTER:
  - pc = 1, play = 0 for HOLD_CYCLES cycles, then go to RELEASE.
  - play and pc are never high in the same cycle.
- RELEASE:
  - Wait until stable_btn == 0.
  - Then go to OVER if who != 00, else IDLE.
  - Presses during PLAYER, COMPUTER or RELEASE are ignored; they do not queue.
- OVER:
  - busy = 0; all presses ignored.
  - Exit only via reset.
- Position outputs hold their last value between moves; they are not cleared.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) for the debounce counter, $clog2(HOLD_CYCLES+1) for the hold counter.

Optional Feature:
- Macro: TTT_CENTRE_FIRST_EN.
- When defined, the computer picks by priority: centre 4, then corners 0, 2, 6, 8, then edges 1, 3, 5, 7; first empty cell wins.
- When undefined, the computer picks the lowest-index empty cell.
- All other timing is identical in both builds.

Decomposition:
- Package ttt_pkg:
  - Cell encodings: CELL_EMPTY = 2'b00, CELL_PLAYER = 2'b01, CELL_PC = 2'b10.
  - WHO_NONE = 2'b00.
  - FSM state enum.
  - NUM_CELLS = 9.
- Sub-module ttt_btn_debounce (parameter DEBOUNCE_CYCLES):
  - Contains the synchroniser, counter and stable-vector register.
  - Outputs stable_btn and press_evt.

Test Plan:
- Reset asserted mid-PLAYER (play = 1) → play drops asynchronously; state IDLE; all outputs 0 after release of reset.
- Empty board, btn = 9'b000000001 held bouncing for 10 cycles, then stable → player_position = 0 with play high for 5 cycles, then computer_position = 1 with pc high for 5 cycles. With TTT_CENTRE_FIRST_EN defined, computer_position = 4 instead.
- board has cell 2 = 01, press btn[2] → illegal pulses once; play and pc stay 0; FSM waits in RELEASE until buttons are released.
- btn = 9'b000010001 (two buttons) → illegal pulse; no move issued.
- Board with only cell 8 empty, press btn[8] → play with player_position = 8; no pc pulse; return to IDLE after release.
- who = 01 after a move → FSM enters OVER once buttons are released; further presses produce no play, pc or illegal until reset.
